color_mapping_mul_pipe: RTL and testbench

- Pipelined, parametrised signed-by-unsigned multiplier with valid/ready handshake and a user tag sideband.
- Applies round-half-up right shift and range clamp to the output width.
- Successor to the combinational fixed-width colour-mapping multipliers. Sits in the color_mapping datapath between intensity normalisation and palette index generation.
- Stalls cleanly under downstream backpressure.

---
 rtl/color_mapping_pkg.sv | 63 ++++++
 rtl/color_mapping_mul_stage.sv | 30 +++
 rtl/color_mapping_mul_pipe.sv | 131 +++++++++++++
 tb/tb_color_mapping_mul_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_mapping_pkg.sv
// Shared constants and arithmetic helpers for the color_mapping multiplier pipeline.
// Build option: COLOR_MAPPING_MUL_SAT_EN selects saturating clamp instead of wrap.
package color_mapping_pkg;

    localparam int MAX_W = 128;

    localparam int DEF_A_W       = 9;
    localparam int DEF_B_W       = 42;
    localparam int DEF_OUT_W     = 50;
    localparam int DEF_SHIFT     = 0;
    localparam int DEF_NUM_STAGE = 3;
    localparam int DEF_TAG_W     = 1;

    // Wide signed working type; every internal product and rounded result fits in it.
    typedef logic signed [MAX_W-1:0] wide_t;

    function automatic int p_width(input int a_w, input int b_w);
        return a_w + b_w + 1;
    endfunction

    function automatic wide_t out_max(input int out_w);
        wide_t one;
        one = wide_t'(1);
        return (one <<< (out_w - 1)) - one;
    endfunction

    function automatic wide_t out_min(input int out_w);
        return ~out_max(out_w);
    endfunction

    // Round half toward +inf, then arithmetic shift.
    function automatic wide_t round_shift(input wide_t p, input int shift);
        wide_t half;
        if (shift == 0) begin
            return p;
        end
        half = wide_t'(1) <<< (shift - 1);
        return (p + half) >>> shift;
    endfunction

    function automatic logic is_ovf(input wide_t r, input wide_t hi, input wide_t lo);
        return (r > hi) || (r < lo);
    endfunction

    function automatic wide_t clamp(input wide_t r, input wide_t hi, input wide_t lo);
`ifdef COLOR_MAPPING_MUL_SAT_EN
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
`else
        // Wrap build: the caller keeps only the low OUT_W bits.
        if (hi < lo) begin
            return r;
        end
        return r;
`endif
    endfunction

endpackage

// File: rtl/color_mapping_mul_stage.sv
// One enabled pipeline register carrying a valid bit, a data word and a tag.
module color_mapping_mul_stage #(
    parameter int DW = 8,
    parameter int TW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          d_valid,
    input  logic [DW-1:0] d_data,
    input  logic [TW-1:0] d_tag,
    output logic          q_valid,
    output logic [DW-1:0] q_data,
    output logic [TW-1:0] q_tag
);

    // NOTE: data and tag are reset too, so nothing stale is observable after a mid-flight reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_tag   <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
            q_tag   <= d_tag;
        end
    end

endmodule

// File: rtl/color_mapping_mul_pipe.sv
// Pipelined signed x unsigned multiplier with round/clamp, valid/ready and tag sideband.
// Build option: COLOR_MAPPING_MUL_SAT_EN saturates out-of-range results instead of wrapping.
module color_mapping_mul_pipe
    import color_mapping_pkg::*;
#(
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int NUM_STAGE = DEF_NUM_STAGE,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf,
    input  logic             clr_ovf
);

    localparam int    P_W     = p_width(A_W, B_W);
    localparam int    DW      = (P_W > OUT_W) ? P_W : OUT_W;
    localparam int    LAST    = NUM_STAGE - 1;
    localparam wide_t OUT_MAX = out_max(OUT_W);
    localparam wide_t OUT_MIN = out_min(OUT_W);

    logic             en;
    logic             st_vd [NUM_STAGE];
    logic             st_vq [NUM_STAGE];
    logic [DW-1:0]    st_dd [NUM_STAGE];
    logic [DW-1:0]    st_dq [NUM_STAGE];
    logic [TAG_W-1:0] st_td [NUM_STAGE];
    logic [TAG_W-1:0] st_tq [NUM_STAGE];

    logic [P_W-1:0]   last_p;
    wide_t            last_r;
    logic             last_ovf;

    // Operands travel as {sign(din0), din0, din1}; the extra sign bit keeps the multiply exact.
    function automatic logic [P_W-1:0] mul_ops(input logic [P_W-1:0] ops);
        logic signed [A_W:0]   a;
        logic signed [B_W:0]   b;
        logic signed [P_W-1:0] p;
        a = ops[P_W-1:B_W];
        b = {1'b0, ops[B_W-1:0]};
        p = a * b;
        return p;
    endfunction

    function automatic logic [OUT_W-1:0] fit_out(input wide_t r);
        wide_t c;
        c = clamp(r, OUT_MAX, OUT_MIN);
        return c[OUT_W-1:0];
    endfunction

    // One global enable: the whole pipe advances or holds together, bubbles included.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = st_vq[LAST];
    assign dout      = st_dq[LAST][OUT_W-1:0];
    assign out_tag   = st_tq[LAST];

    generate
        if (NUM_STAGE == 1) begin : g_p_comb
            assign last_p = mul_ops({din0[A_W-1], din0, din1});
        end else if (NUM_STAGE == 2) begin : g_p_s0
            assign last_p = mul_ops(st_dq[0][P_W-1:0]);
        end else begin : g_p_reg
            assign last_p = st_dq[LAST-1][P_W-1:0];
        end
    endgenerate

    assign last_r   = round_shift({{(MAX_W-P_W){last_p[P_W-1]}}, last_p}, SHIFT);
    assign last_ovf = is_ovf(last_r, OUT_MAX, OUT_MIN);

    generate
        for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
            if (i == 0) begin : g_head
                assign st_vd[i] = in_valid && en;
                assign st_td[i] = in_tag;
            end else begin : g_chain
                assign st_vd[i] = st_vq[i-1];
                assign st_td[i] = st_tq[i-1];
            end

            if (i == LAST) begin : g_fin
                assign st_dd[i] = DW'(fit_out(last_r));
            end else if (i == 0) begin : g_ops
                assign st_dd[i] = DW'({din0[A_W-1], din0, din1});
            end else if (i == 1) begin : g_mul
                assign st_dd[i] = DW'(mul_ops(st_dq[0][P_W-1:0]));
            end else begin : g_pass
                assign st_dd[i] = st_dq[i-1];
            end

            color_mapping_mul_stage #(
                .DW (DW),
                .TW (TAG_W)
            ) u_stage (
                .clk     (ap_clk),
                .rst_n   (ap_rst_n),
                .en      (en),
                .d_valid (st_vd[i]),
                .d_data  (st_dd[i]),
                .d_tag   (st_td[i]),
                .q_valid (st_vq[i]),
                .q_data  (st_dq[i]),
                .q_tag   (st_tq[i])
            );
        end
    endgenerate

    // Sticky overflow: a beat landing in the output register wins over a same-cycle clear.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ovf <= 1'b0;
        end else if (en && st_vd[LAST] && last_ovf) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_color_mapping_mul_pipe.sv
// Directed self-checking bench for color_mapping_mul_pipe (A_W=9, B_W=8, OUT_W=12, SHIFT=4, 3 stages).
module tb_color_mapping_mul_pipe;

    localparam int A_W       = 9;
    localparam int B_W       = 8;
    localparam int OUT_W     = 12;
    localparam int SHIFT     = 4;
    localparam int NUM_STAGE = 3;
    localparam int TAG_W     = 1;

`ifdef COLOR_MAPPING_MUL_SAT_EN
    localparam logic [OUT_W-1:0] EXP_POS = 12'h7FF;
    localparam logic [OUT_W-1:0] EXP_NEG = 12'h800;
`else
    localparam logic [OUT_W-1:0] EXP_POS = 12'hFE0;
    localparam logic [OUT_W-1:0] EXP_NEG = 12'h010;
`endif

    logic             ap_clk    = 1'b0;
    logic             ap_rst_n  = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [A_W-1:0]   din0      = '0;
    logic [B_W-1:0]   din1      = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] dout;
    logic [TAG_W-1:0] out_tag;
    logic             ovf;
    logic             clr_ovf   = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [TAG_W-1:0] t;
        int               c;
    } exp_t;

    exp_t             exp_q [$];
    bit               mon_en    = 1'b0;
    bit               chk_lat   = 1'b0;
    int               got       = 0;
    logic             hold_prev = 1'b0;
    logic [OUT_W-1:0] prev_dout = '0;
    logic [TAG_W-1:0] prev_tag  = '0;

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cycle <= cycle + 1;

    color_mapping_mul_pipe #(
        .A_W       (A_W),
        .B_W       (B_W),
        .OUT_W     (OUT_W),
        .SHIFT     (SHIFT),
        .NUM_STAGE (NUM_STAGE),
        .TAG_W     (TAG_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_tag   (out_tag),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact product, +8, floor-divide by 16 done with integer division.
    function automatic int m_r(input int a, input int b);
        int p;
        p = a * b + 8;
        if (p >= 0) return p / 16;
        return -((-p + 15) / 16);
    endfunction

    function automatic logic [OUT_W-1:0] m_dout(input int r);
        logic [31:0] rv;
`ifdef COLOR_MAPPING_MUL_SAT_EN
        if (r > 2047) return 12'h7FF;
        if (r < -2048) return 12'h800;
`endif
        rv = r;
        return rv[OUT_W-1:0];
    endfunction

    function automatic void push_exp(input int a, input int b, input logic [TAG_W-1:0] tg);
        exp_t e;
        e.d = m_dout(m_r(a, b));
        e.t = tg;
        e.c = cycle;
        exp_q.push_back(e);
    endfunction

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic run_single(input string name, input int a, input int b, input logic [TAG_W-1:0] tg,
                              input logic [OUT_W-1:0] ed, input logic eo);
        din0      = A_W'(a);
        din1      = B_W'(b);
        in_tag    = tg;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        check({name, "_early"}, out_valid, 0);
        tick;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_dout"}, dout, ed);
        check({name, "_tag"}, out_tag, tg);
        check({name, "_ovf"}, ovf, eo);
        tick;
        check({name, "_drain"}, out_valid, 0);
    endtask

    // Output monitor: ordering, data, tag, latency, hold-while-stalled, in_ready rule.
    always @(negedge ap_clk) begin : mon
        exp_t e;
        if (mon_en) begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_dout", dout, prev_dout);
                check("hold_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_dout", dout, e.d);
                    check("out_tag", out_tag, e.t);
                    if (chk_lat) check("latency", cycle, e.c + NUM_STAGE);
                    got++;
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_dout = dout;
            prev_tag  = out_tag;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int bp_a [8];
        int bp_b [8];
        int idx;
        int cyc;
        int a;
        int b;
        int accepts;
        int stale;

        bp_a = '{-3, 255, 1, -1, 7, -256, 100, -128};
        bp_b = '{200, 255, 1, 8, 9, 255, 17, 128};

        // Reset state
        repeat (3) tick;
        check("rst_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_tag", out_tag, 0);
        check("rst_ovf", ovf, 0);
        ap_rst_n = 1'b1;
        tick;
        check("rel_in_ready", in_ready, 1);

        // Rounding, positive and negative extremes
        run_single("round", -3, 200, 1'b1, 12'hFDB, 1'b0);
        run_single("pos_ovf", 255, 255, 1'b0, EXP_POS, 1'b1);
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        check("clr_after_pos", ovf, 0);
        run_single("neg_ext", -256, 255, 1'b1, EXP_NEG, 1'b1);
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        check("clr_after_neg", ovf, 0);

        // Backpressure: 8 back-to-back beats, out_ready low for cycles 4..8
        mon_en  = 1'b1;
        chk_lat = 1'b0;
        got     = 0;
        idx     = 0;
        cyc     = 0;
        while ((idx < 8 || exp_q.size() != 0) && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                din0   = A_W'(bp_a[idx]);
                din1   = B_W'(bp_b[idx]);
                in_tag = TAG_W'(idx % 2);
            end
            @(negedge ap_clk);
            if (in_valid && in_ready) begin
                push_exp(bp_a[idx], bp_b[idx], TAG_W'(idx % 2));
                idx++;
            end
            tick;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", got, 8);
        check("bp_pending", exp_q.size(), 0);
        tick;
        mon_en = 1'b0;

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            din0     = A_W'(100 + i);
            din1     = B_W'(50);
            in_tag   = 1'b1;
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        ap_rst_n = 1'b0;
        tick;
        check("midrst_valid", out_valid, 0);
        check("midrst_dout", dout, 0);
        check("midrst_tag", out_tag, 0);
        ap_rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (out_valid) stale++;
        end
        check("midrst_no_stale", stale, 0);
        run_single("post_rst", 5, 48, 1'b0, 12'h00F, 1'b0);

        // Same-cycle set and clear of ovf: set wins
        clr_ovf  = 1'b1;
        tick;
        clr_ovf  = 1'b0;
        check("sticky_pre_clear", ovf, 0);
        din0     = A_W'(255);
        din1     = B_W'(255);
        in_tag   = 1'b0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        clr_ovf  = 1'b1;
        tick;
        clr_ovf  = 1'b0;
        check("sticky_set_wins", ovf, 1);
        check("sticky_beat_out", out_valid, 1);
        tick;
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        check("sticky_cleared", ovf, 0);

        // Throughput: 100 random beats, one per cycle
        mon_en    = 1'b1;
        chk_lat   = 1'b1;
        got       = 0;
        accepts   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a        = int'($urandom_range(0, 511)) - 256;
            b        = int'($urandom_range(0, 255));
            din0     = A_W'(a);
            din1     = B_W'(b);
            in_tag   = TAG_W'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(negedge ap_clk);
            if (in_ready) begin
                push_exp(a, b, in_tag);
                accepts++;
            end
            tick;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick;
        check("rnd_accepts", accepts, 100);
        check("rnd_count", got, 100);
        check("rnd_pending", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
